// File: rtl/mdu_issue.sv
`default_nettype none
// ============================================================================
// mdu_issue : execute-stage sequencer for mdu, with *W shaping and div fast path
// Rev 1.0
// ============================================================================
module mdu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            mdu_mul,
  output logic            mdu_mulh,
  output logic            mdu_mulhsu,
  output logic            mdu_mulhu,
  output logic            mdu_div,
  output logic            mdu_divu,
  output logic            mdu_rem,
  output logic            mdu_remu,
  output logic [XLEN-1:0] mdu_src1,
  output logic [XLEN-1:0] mdu_src2,
  output logic            mdu_flush,
  input  logic [XLEN-1:0] mdu_result,
  input  logic            mdu_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] C_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [31:0]     C_WORD_MIN = 32'h8000_0000;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      lines_q, lines_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            word_q, word_d;
  logic [4:0]      rd_q, rd_d;

  logic            accept;
  logic            is_mulh;
  logic            word_eff;
  logic [XLEN-1:0] src1_sh;
  logic [XLEN-1:0] src2_sh;
  logic            div_zero;
  logic            sgn_ovf;
  logic            min_hit;
  logic [XLEN-1:0] fast_res;

  assign in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign mdu_flush = flush;

  always_comb begin
    accept   = in_valid & in_ready;
    is_mulh  = ~in_op[2] & (in_op[1:0] != 2'd0);
    word_eff = in_word & ~is_mulh;

    // Word divides see 32-bit operands; mulw needs the full operands untouched.
    src1_sh = in_src1;
    src2_sh = in_src2;
    if (word_eff && in_op[2]) begin
      src1_sh = in_op[0] ? zext32(in_src1[31:0]) : sext32(in_src1[31:0]);
      src2_sh = in_op[0] ? zext32(in_src2[31:0]) : sext32(in_src2[31:0]);
    end

    div_zero = in_op[2] & (src2_sh == '0);
    min_hit  = word_eff ? (src1_sh[31:0] == C_WORD_MIN) : (src1_sh == C_MIN);
    sgn_ovf  = in_op[2] & ~in_op[0] & min_hit & (src2_sh == '1);

    fast_res = '0;
    if (div_zero) begin
      if (in_op[1]) fast_res = word_eff ? sext32(src1_sh[31:0]) : src1_sh;
      else          fast_res = '1;
    end else if (sgn_ovf) begin
      fast_res = in_op[1] ? '0 : src1_sh;
    end

    state_d  = state_q;
    lines_d  = lines_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    word_d   = word_q;
    rd_d     = rd_q;

    case (state_q)
      S_ISSUE: begin
        // Drop the op lines after capture so mdu sees a low cycle and rearms.
        if (mdu_ready && (lines_q != 8'd0)) begin
          result_d = word_q ? sext32(mdu_result[31:0]) : mdu_result;
          lines_d  = 8'd0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      src1_d = src1_sh;
      src2_d = src2_sh;
      word_d = word_eff;
      rd_d   = in_rd;
      if (div_zero || sgn_ovf) begin
        result_d = fast_res;
        lines_d  = 8'd0;
        state_d  = S_DONE;
      end else begin
        lines_d  = 8'd1 << in_op;
        state_d  = S_ISSUE;
      end
    end

    if (flush) begin
      state_d = S_IDLE;
      lines_d = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lines_q  <= 8'd0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      word_q   <= 1'b0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      lines_q  <= lines_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      word_q   <= word_d;
      rd_q     <= rd_d;
    end
  end

  assign {mdu_remu, mdu_rem, mdu_divu, mdu_div,
          mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul} = lines_q;
  assign mdu_src1   = src1_q;
  assign mdu_src2   = src2_q;
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mdu_issue.md
# mdu_issue

Execute-stage sequencer in front of `mdu`. Accepts one M-extension op per handshake from ID/EX and drives `mdu`'s one-hot op lines and operands until its `ready` reports a result. Holds the result for the downstream stage under valid/ready backpressure. Adds RV64 word-op (`*W`) operand/result shaping and resolves divide-by-zero and signed overflow locally, without starting `mdu`.

## Interface

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill the in-flight op and any held result.
- in_valid  in  1  op offered by ID/EX.
- in_ready  out  1  op can be accepted this cycle.
- in_op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- in_word  in  1  `*W` variant; honoured for mul/div/divu/rem/remu, ignored for mulh*.
- in_src1, in_src2  in  64  operands.
- in_rd  in  5  destination tag, passed through.
- mdu_mul … mdu_remu  out  1 each  one-hot op lines to `mdu` (8 ports).
- mdu_src1, mdu_src2  out  64  shaped operands to `mdu`.
- mdu_flush  out  1  equals `flush` (combinational).
- mdu_result  in  64  `mdu` result.
- mdu_ready  in  1  `mdu` ready/valid.
- out_valid  out  1  result held for downstream.
- out_ready  in  1  downstream accepts.
- out_result  out  64  final rd value.
- out_rd  out  5  tag.
- busy  out  1  state != IDLE, for hazard/stall logic.

## Operation

- FSM states: IDLE, ISSUE, DONE.
- Acceptance (`in_valid & in_ready`):
  - Latch op, word, rd and the shaped operands.
  - Go to DONE if a fast-path case applies; otherwise go to ISSUE.
- `in_ready = ~flush & (IDLE | (DONE & out_ready))`. Back-to-back issue is allowed on the same cycle as result drain.
- Operand shaping:
  - Word div/rem (signed): sign-extend `[31:0]` of both operands.
  - Word divu/remu: zero-extend `[31:0]` of both operands.
  - mulw and all non-word ops: operands pass unchanged.
- ISSUE:
  - Exactly one `mdu_*` line is high, constant, with constant operands.
  - On `mdu_ready` with a line high: capture `mdu_result` (shaped), go to DONE.
  - All op lines drop the next cycle. `mdu` needs one op-low cycle to rearm its sub-units.
- Result shaping: word ops return `sext(mdu_result[31:0])`; non-word ops return `mdu_result`.
- Fast path, evaluated on shaped operands at acceptance:
  - Divide-by-zero (src2 == 0):
    - div/divu return all ones; word forms also return all ones.
    - rem/remu return the dividend; word forms return `sext(src1[31:0])`.
  - Signed overflow on div/rem:
    - 64-bit case: src1 = 0x8000_0000_0000_0000 and src2 = all ones.
    - Word case: low halves 0x8000_0000 and 0xFFFF_FFFF.
    - div returns src1 (word form: sext 0x8000_0000); rem returns 0.
- DONE:
  - `out_valid = 1`, with result and rd stable until `out_ready`.
  - Then go to IDLE, or to ISSUE/DONE if a new op is accepted in the same cycle.
- Flush (synchronous effect):
  - State goes to IDLE next cycle and all `mdu_*` lines are low next cycle.
  - `mdu_flush` is asserted in the same cycle as `flush`.
  - `out_valid` is 0 from the next cycle; nothing is accepted in the flush cycle.
  - Flush has priority over a simultaneous `mdu_ready` or `out_ready`.
- reset low:
  - State is IDLE; `out_valid`, `busy` and all `mdu_*` lines are 0.
  - `out_result`, `out_rd`, `mdu_src*` are 0.
  - `in_ready` is 1 combinationally, since `flush` is 0.

## Timing

- All state changes on the rising clock edge.
- `in_*` is sampled at the acceptance edge; `mdu_*` lines are high from the following cycle.
- mdu path latency: acceptance edge + N `mdu` cycles + 1. `out_valid` rises the cycle after `mdu_ready` is sampled.
- Fast-path latency: `out_valid` is high in the cycle after acceptance. `mdu` op lines stay low throughout.
- `mdu_ready` while no op line is high is ignored. This includes `mdu`'s idle-ready.
- Backpressure: `out_valid` and `out_result` hold indefinitely while `out_ready` = 0.
- Reset asserted mid-ISSUE: the op is abandoned and `mdu` is not flushed explicitly. All op lines are 0 from reset, and `mdu` rearms when its inputs drop.

## Test plan

- Non-word mul: src1 = 3, src2 = 0xFFFF_FFFF_FFFF_FFFB, out_ready = 1.
  - Exactly one `mdu_mul` pulse train.
  - out_result = 0xFFFF_FFFF_FFFF_FFF1, one cycle after `mdu_ready`.
- divw: src1 = 0x0000_0001_FFFF_FFF9 (−7 low), src2 = 2.
  - `mdu_src1` = 0xFFFF_FFFF_FFFF_FFF9.
  - out_result = 0xFFFF_FFFF_FFFF_FFFD.
- Fast-path rem, src2 = 0, src1 = 0x1234:
  - No `mdu_*` line ever asserted.
  - out_result = 0x1234, out_valid the next cycle.
  - divu by 0 gives all ones.
- Overflow, div with src1 = 0x8000_0000_0000_0000, src2 = all ones:
  - out_result = 0x8000_0000_0000_0000; rem gives 0.
- Flush 2 cycles into an ISSUE of div:
  - `mdu_flush` is high in the same cycle.
  - Op lines are low and busy = 0 next cycle; no out_valid ever.
  - A new op is accepted the cycle after the flush.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after out_valid: result stable, in_ready = 0.
  - Raise out_ready with a new mul on in_valid: drain and accept occur on the same edge.
